// File: rtl/qos_csr_bank.sv
// QoS channel-selection CSR bank: shadowed configuration with explicit commit,
// input snapshots for status/error reads, sticky signal-loss flags and interrupt.
module qos_csr_bank #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned ERR_W   = 8,
    parameter int unsigned TIMER_W = 20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mm_write_en,
    input  logic                            mm_read_en,
    input  logic [7:0]                      mm_addr,
    input  logic [31:0]                     mm_wdata,
    output logic [31:0]                     mm_rdata,
    output logic                            mm_rvalid,
    output logic                            mm_error,
    output logic                            fallback_enable,
    output logic                            manual_enable,
    output logic [$clog2(N_CH)-1:0]         manual_channel,
    output logic [$clog2(N_CH)*N_CH-1:0]    channel_priority,
    output logic [TIMER_W-1:0]              reset_timer,
    output logic                            valid_config,
    output logic                            irq,
    input  logic [$clog2(N_CH)-1:0]         active_channel,
    input  logic [N_CH-1:0]                 signal_present,
    input  logic [N_CH*ERR_W-1:0]           error_count
);

    localparam int unsigned CW  = $clog2(N_CH);
    localparam int unsigned PW  = CW * N_CH;
    localparam int unsigned CTW = CW + 2;
    localparam logic [31:0] ID_VAL = {8'h02, 8'(N_CH), 8'(ERR_W), 8'(TIMER_W)};

    typedef enum logic [7:0] {
        ADDR_CTRL   = 8'h00,
        ADDR_PRIO   = 8'h01,
        ADDR_TIMER  = 8'h02,
        ADDR_COMMIT = 8'h03,
        ADDR_STATUS = 8'h04,
        ADDR_LOSS   = 8'h05,
        ADDR_IRQ_EN = 8'h06,
        ADDR_ID     = 8'h07,
        ADDR_ERR0   = 8'h08
    } addr_e;

    logic [CTW-1:0]        r_ctrl_sh, r_ctrl_act;
    logic [PW-1:0]         r_prio_sh, r_prio_act;
    logic [TIMER_W-1:0]    r_timer_sh, r_timer_act;
    logic [N_CH-1:0]       r_loss, r_irq_en, r_sig_snap;
    logic [CW-1:0]         r_act_snap;
    logic [N_CH*ERR_W-1:0] r_err_snap;
    logic [31:0]           r_rdata;
    logic                  r_rvalid, r_error, r_valid_cfg, r_irq;

    logic [31:0]           w_rdata;
    logic                  w_rd_bad, w_wr_bad, w_commit;
    logic [N_CH-1:0]       w_loss_clr;
    logic                  w_unused_wdata;

    assign w_unused_wdata = ^mm_wdata;

    always_comb begin
        w_rdata  = '0;
        w_rd_bad = 1'b0;
        case (mm_addr)
            ADDR_CTRL:   w_rdata = 32'(r_ctrl_sh);
            ADDR_PRIO:   w_rdata = 32'(r_prio_sh);
            ADDR_TIMER:  w_rdata = 32'(r_timer_sh);
            ADDR_STATUS: w_rdata = 32'({r_sig_snap, 4'(r_act_snap)});
            ADDR_LOSS:   w_rdata = 32'(r_loss);
            ADDR_IRQ_EN: w_rdata = 32'(r_irq_en);
            ADDR_ID:     w_rdata = ID_VAL;
            default: begin
                // COMMIT and everything past the last ERR slot read as an error
                w_rd_bad = 1'b1;
                for (int unsigned k = 0; k < N_CH; k++) begin
                    if (mm_addr == 8'(ADDR_ERR0 + k)) begin
                        w_rdata  = 32'(r_err_snap[k*ERR_W +: ERR_W]);
                        w_rd_bad = 1'b0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (mm_addr)
            ADDR_CTRL, ADDR_PRIO, ADDR_TIMER,
            ADDR_COMMIT, ADDR_LOSS, ADDR_IRQ_EN: w_wr_bad = 1'b0;
            default:                             w_wr_bad = 1'b1;
        endcase
    end

    assign w_commit   = mm_write_en && (mm_addr == ADDR_COMMIT) && mm_wdata[0];
    assign w_loss_clr = (mm_write_en && (mm_addr == ADDR_LOSS)) ? mm_wdata[N_CH-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl_sh   <= '0;
            r_prio_sh   <= '0;
            r_timer_sh  <= '0;
            r_ctrl_act  <= '0;
            r_prio_act  <= '0;
            r_timer_act <= '0;
            r_loss      <= '0;
            r_irq_en    <= '0;
            r_sig_snap  <= '0;
            r_act_snap  <= '0;
            r_err_snap  <= '0;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_error     <= 1'b0;
            r_valid_cfg <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_sig_snap  <= signal_present;
            r_act_snap  <= active_channel;
            r_err_snap  <= error_count;
            // A new fall on the snapshot overrides a same-cycle W1C clear
            r_loss      <= (r_loss & ~w_loss_clr) | (r_sig_snap & ~signal_present);
            r_irq       <= |(r_loss & r_irq_en);
            r_rvalid    <= mm_read_en;
            r_error     <= (mm_read_en & w_rd_bad) | (mm_write_en & w_wr_bad);
            r_valid_cfg <= w_commit;
            if (mm_read_en)
                r_rdata <= w_rdata;
            if (mm_write_en) begin
                case (mm_addr)
                    ADDR_CTRL:   r_ctrl_sh  <= mm_wdata[CTW-1:0];
                    ADDR_PRIO:   r_prio_sh  <= mm_wdata[PW-1:0];
                    ADDR_TIMER:  r_timer_sh <= mm_wdata[TIMER_W-1:0];
                    ADDR_IRQ_EN: r_irq_en   <= mm_wdata[N_CH-1:0];
                    default: ;
                endcase
            end
            if (w_commit) begin
                r_ctrl_act  <= r_ctrl_sh;
                r_prio_act  <= r_prio_sh;
                r_timer_act <= r_timer_sh;
            end
        end
    end

    assign mm_rdata         = r_rdata;
    assign mm_rvalid        = r_rvalid;
    assign mm_error         = r_error;
    assign fallback_enable  = r_ctrl_act[0];
    assign manual_enable    = r_ctrl_act[1];
    assign manual_channel   = r_ctrl_act[CTW-1:2];
    assign channel_priority = r_prio_act;
    assign reset_timer      = r_timer_act;
    assign valid_config     = r_valid_cfg;
    assign irq              = r_irq;

endmodule

// File: tb/tb_qos_csr_bank.sv
// Bench for qos_csr_bank: randomized and directed bus traffic on a 4-channel
// instance against a register-map model, plus directed checks on an 8-channel instance.
module tb_qos_csr_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, re;
    logic [7:0]  addr;
    logic [31:0] wdata;

    logic [1:0]   act_a;
    logic [3:0]   sig_a;
    logic [31:0]  err_a;
    logic [31:0]  a_rdata;
    logic         a_rvalid, a_error, a_fb, a_me, a_vc, a_irq;
    logic [1:0]   a_mc;
    logic [7:0]   a_prio;
    logic [19:0]  a_timer;

    logic [2:0]   act_b;
    logic [7:0]   sig_b;
    logic [127:0] err_b;
    logic [31:0]  b_rdata;
    logic         b_rvalid, b_error, b_fb, b_me, b_vc, b_irq;
    logic [2:0]   b_mc;
    logic [23:0]  b_prio;
    logic [31:0]  b_timer;

    qos_csr_bank #(.N_CH(4), .ERR_W(8), .TIMER_W(20)) u_dut_a (
        .clk(clk), .rst(rst), .mm_write_en(we), .mm_read_en(re), .mm_addr(addr),
        .mm_wdata(wdata), .mm_rdata(a_rdata), .mm_rvalid(a_rvalid), .mm_error(a_error),
        .fallback_enable(a_fb), .manual_enable(a_me), .manual_channel(a_mc),
        .channel_priority(a_prio), .reset_timer(a_timer), .valid_config(a_vc), .irq(a_irq),
        .active_channel(act_a), .signal_present(sig_a), .error_count(err_a)
    );

    qos_csr_bank #(.N_CH(8), .ERR_W(16), .TIMER_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .mm_write_en(we), .mm_read_en(re), .mm_addr(addr),
        .mm_wdata(wdata), .mm_rdata(b_rdata), .mm_rvalid(b_rvalid), .mm_error(b_error),
        .fallback_enable(b_fb), .manual_enable(b_me), .manual_channel(b_mc),
        .channel_priority(b_prio), .reset_timer(b_timer), .valid_config(b_vc), .irq(b_irq),
        .active_channel(act_b), .signal_present(sig_b), .error_count(err_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model of the 4-channel instance: shadows, active copy, flags, snapshots
    bit [31:0] m_ctrl, m_prio, m_timer, v_ctrl, v_prio, v_timer;
    bit [31:0] m_loss, m_irqen, s_sig, s_act, s_err, m_rdata;
    logic [3:0] sig_cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] model_read(input bit [7:0] a, output bit bad);
        bad = 1'b0;
        case (a)
            8'h00: return m_ctrl;
            8'h01: return m_prio;
            8'h02: return m_timer;
            8'h04: return (s_sig << 4) | s_act;
            8'h05: return m_loss;
            8'h06: return m_irqen;
            8'h07: return 32'h0204_0814;
            8'h08, 8'h09, 8'h0A, 8'h0B:
                return (s_err >> (32'(a - 8'h08) * 32'd8)) & 32'hFF;
            default: begin
                bad = 1'b1;
                return 32'h0;
            end
        endcase
    endfunction

    task automatic model_clear();
        m_ctrl = '0; m_prio = '0; m_timer = '0;
        v_ctrl = '0; v_prio = '0; v_timer = '0;
        m_loss = '0; m_irqen = '0; s_sig = '0; s_act = '0; s_err = '0; m_rdata = '0;
    endtask

    task automatic step(input bit w, input bit r, input bit [7:0] a, input bit [31:0] d,
                        input bit [3:0] sg);
        bit [31:0] rd;
        bit bad, e_err, e_vc, e_irq;
        we = w; re = r; addr = a; wdata = d; sig_a = sg;
        e_err = 1'b0;
        if (r) begin
            rd = model_read(a, bad);
            m_rdata = rd;
            e_err = bad;
        end
        if (w && !(a inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06}))
            e_err = 1'b1;
        e_irq = |(m_loss & m_irqen);
        e_vc  = w && (a == 8'h03) && d[0];
        m_loss = (m_loss & ~((w && a == 8'h05) ? (d & 32'hF) : 32'h0)) | (s_sig & ~{28'h0, sg});
        if (w) begin
            case (a)
                8'h00: m_ctrl  = d & 32'hF;
                8'h01: m_prio  = d & 32'hFF;
                8'h02: m_timer = d & 32'hF_FFFF;
                8'h06: m_irqen = d & 32'hF;
                default: ;
            endcase
        end
        if (e_vc) begin
            v_ctrl = m_ctrl; v_prio = m_prio; v_timer = m_timer;
        end
        s_sig = {28'h0, sg}; s_act = {30'h0, act_a}; s_err = err_a;
        @(posedge clk);
        #1;
        chk("rvalid",       32'(a_rvalid), 32'(r));
        chk("rdata",        a_rdata, m_rdata);
        chk("mm_error",     32'(a_error), 32'(e_err));
        chk("valid_config", 32'(a_vc), 32'(e_vc));
        chk("irq",          32'(a_irq), 32'(e_irq));
        chk("fallback",     32'(a_fb), 32'(v_ctrl[0]));
        chk("manual_en",    32'(a_me), 32'(v_ctrl[1]));
        chk("manual_ch",    32'(a_mc), 32'(v_ctrl[3:2]));
        chk("priority",     32'(a_prio), v_prio);
        chk("timer",        32'(a_timer), v_timer);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 32'h0, sig_cur);
    endtask

    task automatic do_reset();
        rst = 1'b1; we = 1'b0; re = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rdata",  a_rdata, 32'h0);
        chk("rst_rvalid", 32'(a_rvalid), 32'h0);
        chk("rst_error",  32'(a_error), 32'h0);
        chk("rst_vc",     32'(a_vc), 32'h0);
        chk("rst_irq",    32'(a_irq), 32'h0);
        chk("rst_timer",  32'(a_timer), 32'h0);
        chk("rst_b_rdata", b_rdata, 32'h0);
        chk("rst_b_fb",    32'(b_fb), 32'h0);
        chk("rst_b_timer", b_timer, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        act_a = '0; sig_a = '0; err_a = '0;
        act_b = '0; sig_b = '0; err_b = '0;
        sig_cur = 4'hF;
        #12;
        do_reset();

        // Shadow write, read-back, then commit
        step(1'b1, 1'b0, 8'h00, 32'h0000_0007, sig_cur);
        step(1'b0, 1'b1, 8'h00, 32'h0, sig_cur);
        chk("ctrl_readback", a_rdata, 32'h7);
        chk("fb_before_commit", 32'(a_fb), 32'h0);
        step(1'b1, 1'b0, 8'h03, 32'h0000_0001, sig_cur);
        chk("vc_pulse", 32'(a_vc), 32'h1);
        chk("mc_after_commit", 32'(a_mc), 32'h1);
        idle(1);
        chk("vc_single", 32'(a_vc), 32'h0);
        step(1'b1, 1'b0, 8'h03, 32'h0000_0000, sig_cur);

        // Error counter snapshot read
        err_a = 32'h00A5_0000;
        idle(1);
        step(1'b0, 1'b1, 8'h0A, 32'h0, sig_cur);
        chk("err2_read", a_rdata, 32'h0000_00A5);

        // Loss flag, interrupt, clear, clear racing a new fall
        step(1'b1, 1'b0, 8'h06, 32'h4, sig_cur);
        step(1'b0, 1'b0, 8'h00, 32'h0, 4'hB);
        idle(1);
        chk("irq_set", 32'(a_irq), 32'h1);
        step(1'b0, 1'b1, 8'h05, 32'h0, 4'hB);
        chk("loss_read", a_rdata, 32'h4);
        step(1'b1, 1'b0, 8'h05, 32'h4, 4'hB);
        step(1'b0, 1'b0, 8'h00, 32'h0, 4'hB);
        chk("irq_cleared", 32'(a_irq), 32'h0);
        step(1'b0, 1'b0, 8'h00, 32'h0, 4'hF);
        step(1'b1, 1'b0, 8'h05, 32'h4, 4'hB);
        step(1'b0, 1'b1, 8'h05, 32'h0, 4'hB);
        chk("loss_set_wins", a_rdata, 32'h4);
        step(1'b1, 1'b0, 8'h05, 32'hF, 4'hF);
        step(1'b0, 1'b1, 8'h05, 32'h0, 4'hB);
        chk("loss_read_pre_set", a_rdata, 32'h0);
        idle(2);
        sig_cur = 4'hB;

        // Unmapped read, write to read-only STATUS
        step(1'b0, 1'b1, 8'h20, 32'h0, sig_cur);
        chk("unmapped_rdata", a_rdata, 32'h0);
        chk("unmapped_err", 32'(a_error), 32'h1);
        step(1'b1, 1'b0, 8'h04, 32'hFFFF_FFFF, sig_cur);
        chk("ro_write_err", 32'(a_error), 32'h1);
        step(1'b0, 1'b1, 8'h04, 32'h0, sig_cur);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit [7:0] a;
            int unsigned r;
            r = $urandom_range(19, 0);
            a = (r < 16) ? 8'(r) : ((r < 18) ? 8'h20 : 8'hFF);
            if ($urandom_range(3, 0) == 0)
                sig_cur = sig_cur ^ 4'(1 << $urandom_range(3, 0));
            act_a = 2'($urandom);
            err_a = $urandom;
            step(($urandom_range(2, 0) == 0), 1'($urandom), a, $urandom, sig_cur);
        end

        // Reset arriving during a commit write and a read
        step(1'b1, 1'b0, 8'h00, 32'h5, sig_cur);
        step(1'b1, 1'b0, 8'h02, 32'h12345, sig_cur);
        we = 1'b1; re = 1'b1; addr = 8'h03; wdata = 32'h1;
        #2;
        do_reset();
        chk("rst_commit_fb", 32'(a_fb), 32'h0);
        idle(1);
        chk("no_vc_after_rst", 32'(a_vc), 32'h0);
        chk("no_rvalid_after_rst", 32'(a_rvalid), 32'h0);
        idle(1);

        // Wide instance: commit, error counter, ID, unused bits, full-width timer
        err_b = 128'h0;
        err_b[47:32] = 16'h00A5;
        step(1'b1, 1'b0, 8'h00, 32'h0000_0007, sig_cur);
        step(1'b0, 1'b1, 8'h00, 32'h0, sig_cur);
        chk("b_ctrl_readback", b_rdata, 32'h7);
        chk("b_fb_before", 32'(b_fb), 32'h0);
        step(1'b1, 1'b0, 8'h03, 32'h1, sig_cur);
        chk("b_vc_pulse", 32'(b_vc), 32'h1);
        chk("b_fb", 32'(b_fb), 32'h1);
        chk("b_me", 32'(b_me), 32'h1);
        chk("b_mc", 32'(b_mc), 32'h1);
        idle(1);
        chk("b_vc_single", 32'(b_vc), 32'h0);
        step(1'b0, 1'b1, 8'h0A, 32'h0, sig_cur);
        chk("b_err2_read", b_rdata, 32'h0000_00A5);
        chk("b_err2_rvalid", 32'(b_rvalid), 32'h1);
        step(1'b0, 1'b1, 8'h07, 32'h0, sig_cur);
        chk("b_id", b_rdata, 32'h0208_1020);
        step(1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF, sig_cur);
        step(1'b0, 1'b1, 8'h00, 32'h0, sig_cur);
        chk("b_ctrl_unused", b_rdata, 32'h1F);
        step(1'b1, 1'b0, 8'h02, 32'hFFFF_FFFF, sig_cur);
        step(1'b1, 1'b0, 8'h03, 32'h1, sig_cur);
        chk("b_timer_full", b_timer, 32'hFFFF_FFFF);
        step(1'b0, 1'b1, 8'h10, 32'h0, sig_cur);
        chk("b_err_slot_last_unmapped", 32'(b_error), 32'h1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
